sparc_window_ctrl: RTL and testbench

- Register-window controller for the SPARC integer register file built from the team's 32-bit general-purpose registers (Clk/Clr/Le per register).
- Holds CWP and WIM, and executes SAVE/RESTORE with overflow/underflow trap detection.
- Maps logical r0..r31 to physical register indices for one write port and two read ports.
- Drives the one-hot Le vector that loads exactly one physical register per write.

---
 rtl/sparc_regfile_pkg.sv | 40 ++++
 rtl/sparc_window_ctrl_if.sv | 43 ++++
 rtl/sparc_window_map.sv | 26 ++
 rtl/sparc_window_ctrl.sv | 115 +++++++++++
 tb/tb_sparc_window_ctrl.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sparc_regfile_pkg.sv
// Shared sizing, register-group bases, FSM encoding and window arithmetic
// for the SPARC windowed register file.
package sparc_regfile_pkg;

    localparam int unsigned NWINDOWS = 8;
    localparam int unsigned CWP_W    = $clog2(NWINDOWS);
    localparam int unsigned NPHYS    = 8 + 16 * NWINDOWS;
    localparam int unsigned PIDX_W   = $clog2(NPHYS);
    localparam int unsigned CWPX_W   = CWP_W + 1;

    localparam int unsigned GLOBALS = 0;
    localparam int unsigned OUTS    = 8;
    localparam int unsigned LOCALS  = 16;
    localparam int unsigned INS     = 24;

    typedef enum logic {
        IDLE,
        TRAP
    } state_t;

    // Values may reach 2*NWINDOWS-1, so one conditional subtract suffices
    function automatic logic [CWP_W-1:0] cwp_wrap(input logic [CWP_W:0] v);
        if (v >= CWPX_W'(NWINDOWS))
            return CWP_W'(v - CWPX_W'(NWINDOWS));
        return CWP_W'(v);
    endfunction

    function automatic logic [CWP_W-1:0] cwp_inc(input logic [CWP_W-1:0] c);
        return cwp_wrap({1'b0, c} + CWPX_W'(1));
    endfunction

    function automatic logic [CWP_W-1:0] cwp_dec(input logic [CWP_W-1:0] c);
        return (c == '0) ? CWP_W'(NWINDOWS - 1) : c - CWP_W'(1);
    endfunction

    function automatic logic [PIDX_W-1:0] window_base(input logic [CWP_W-1:0] w);
        return PIDX_W'(OUTS) + (PIDX_W'(w) << 4);
    endfunction

endpackage

// File: rtl/sparc_window_ctrl_if.sv
// Control, trap handshake and register-port bundle of the window controller.
interface sparc_window_ctrl_if;
    import sparc_regfile_pkg::*;

    logic              save_req;
    logic              restore_req;
    logic              op_ack;
    logic              trap_ovf;
    logic              trap_unf;
    logic              trap_ack;
    logic              busy;
    logic              op_err;
    logic              cwp_we;
    logic [CWP_W-1:0]  cwp_din;
    logic              wim_we;
    logic [NWINDOWS-1:0] wim_din;
    logic [CWP_W-1:0]  cwp;
    logic [NWINDOWS-1:0] wim;
    logic              wr_en;
    logic [4:0]        wr_rd;
    logic [NPHYS-1:0]  le;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [PIDX_W-1:0] rs1_pidx;
    logic [PIDX_W-1:0] rs2_pidx;
    logic              rs1_zero;
    logic              rs2_zero;

    modport slave (
        input  save_req, restore_req, trap_ack, cwp_we, cwp_din, wim_we, wim_din,
               wr_en, wr_rd, rs1, rs2,
        output op_ack, trap_ovf, trap_unf, busy, op_err, cwp, wim, le,
               rs1_pidx, rs2_pidx, rs1_zero, rs2_zero
    );

    modport master (
        output save_req, restore_req, trap_ack, cwp_we, cwp_din, wim_we, wim_din,
               wr_en, wr_rd, rs1, rs2,
        input  op_ack, trap_ovf, trap_unf, busy, op_err, cwp, wim, le,
               rs1_pidx, rs2_pidx, rs1_zero, rs2_zero
    );

endinterface

// File: rtl/sparc_window_map.sv
// Combinational logical r0..r31 to physical register index mapper for one port.
module sparc_window_map
    import sparc_regfile_pkg::*;
(
    input  logic [CWP_W-1:0]  cwp_i,
    input  logic [4:0]        rd_i,
    output logic [PIDX_W-1:0] pidx_o
);

    logic [PIDX_W-1:0] off;

    assign off = PIDX_W'(rd_i[2:0]);

    // Ins of window w are the outs of window w+1
    always_comb begin
        if (rd_i < 5'(OUTS))
            pidx_o = PIDX_W'(GLOBALS) + off;
        else if (rd_i < 5'(LOCALS))
            pidx_o = window_base(cwp_i) + off;
        else if (rd_i < 5'(INS))
            pidx_o = window_base(cwp_i) + PIDX_W'(LOCALS - OUTS) + off;
        else
            pidx_o = window_base(cwp_inc(cwp_i)) + off;
    end

endmodule

// File: rtl/sparc_window_ctrl.sv
// SPARC register-window controller: CWP/WIM state, SAVE/RESTORE with
// overflow/underflow traps, and logical-to-physical register port mapping.
module sparc_window_ctrl
    import sparc_regfile_pkg::*;
(
    input  logic               Clk,
    input  logic               Clr,
    sparc_window_ctrl_if.slave bus
);

    state_t              state_q;
    logic [CWP_W-1:0]    cwp_q;
    logic [NWINDOWS-1:0] wim_q;
    logic                op_ack_q;
    logic                op_err_q;
    logic                trap_ovf_q;
    logic                trap_unf_q;
    logic                busy_q;

    logic [CWP_W-1:0]    save_cwp;
    logic [CWP_W-1:0]    restore_cwp;
    logic [CWP_W-1:0]    load_cwp;
    logic [PIDX_W-1:0]   wr_pidx;

    assign save_cwp    = cwp_dec(cwp_q);
    assign restore_cwp = cwp_inc(cwp_q);
    assign load_cwp    = cwp_wrap({1'b0, bus.cwp_din});

    always_ff @(posedge Clk) begin
        if (Clr) begin
            state_q    <= IDLE;
            cwp_q      <= '0;
            wim_q      <= '0;
            op_ack_q   <= 1'b0;
            op_err_q   <= 1'b0;
            trap_ovf_q <= 1'b0;
            trap_unf_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            op_ack_q <= 1'b0;
            op_err_q <= 1'b0;
            if (bus.wim_we)
                wim_q <= bus.wim_din;
            // WIM checks below read wim_q, i.e. the mask from before this edge
            case (state_q)
                IDLE: begin
                    if (bus.cwp_we) begin
                        cwp_q <= load_cwp;
                    end else if (bus.save_req && bus.restore_req) begin
                        op_err_q <= 1'b1;
                    end else if (bus.save_req) begin
                        if (wim_q[save_cwp]) begin
                            trap_ovf_q <= 1'b1;
                            busy_q     <= 1'b1;
                            state_q    <= TRAP;
                        end else begin
                            cwp_q    <= save_cwp;
                            op_ack_q <= 1'b1;
                        end
                    end else if (bus.restore_req) begin
                        if (wim_q[restore_cwp]) begin
                            trap_unf_q <= 1'b1;
                            busy_q     <= 1'b1;
                            state_q    <= TRAP;
                        end else begin
                            cwp_q    <= restore_cwp;
                            op_ack_q <= 1'b1;
                        end
                    end
                end
                TRAP: begin
                    if (bus.cwp_we)
                        cwp_q <= load_cwp;
                    if (bus.trap_ack) begin
                        trap_ovf_q <= 1'b0;
                        trap_unf_q <= 1'b0;
                        busy_q     <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
            endcase
        end
    end

    sparc_window_map u_map_wr (
        .cwp_i  (cwp_q),
        .rd_i   (bus.wr_rd),
        .pidx_o (wr_pidx)
    );

    sparc_window_map u_map_rs1 (
        .cwp_i  (cwp_q),
        .rd_i   (bus.rs1),
        .pidx_o (bus.rs1_pidx)
    );

    sparc_window_map u_map_rs2 (
        .cwp_i  (cwp_q),
        .rd_i   (bus.rs2),
        .pidx_o (bus.rs2_pidx)
    );

    assign bus.le       = (bus.wr_en && (bus.wr_rd != '0)) ? (NPHYS'(1) << wr_pidx) : '0;
    assign bus.rs1_zero = (bus.rs1 == '0);
    assign bus.rs2_zero = (bus.rs2 == '0);

    assign bus.cwp      = cwp_q;
    assign bus.wim      = wim_q;
    assign bus.op_ack   = op_ack_q;
    assign bus.op_err   = op_err_q;
    assign bus.trap_ovf = trap_ovf_q;
    assign bus.trap_unf = trap_unf_q;
    assign bus.busy     = busy_q;

endmodule

// File: tb/tb_sparc_window_ctrl.sv
// Scoreboard bench for sparc_window_ctrl: directed window scenarios followed
// by random traffic, checked against an arithmetic model of the window rules.
module tb_sparc_window_ctrl;
    import sparc_regfile_pkg::*;

    logic Clk = 1'b0;
    logic Clr;

    sparc_window_ctrl_if bus ();

    sparc_window_ctrl dut (
        .Clk (Clk),
        .Clr (Clr),
        .bus (bus)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic                clr;
        logic                save;
        logic                restore;
        logic                ack;
        logic                cwp_we;
        logic [CWP_W-1:0]    cwp_din;
        logic                wim_we;
        logic [NWINDOWS-1:0] wim_din;
        logic                wr_en;
        logic [4:0]          wr_rd;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
    } stim_t;

    typedef struct packed {
        logic                valid;
        logic [NPHYS-1:0]    le;
        logic [PIDX_W-1:0]   p1;
        logic [PIDX_W-1:0]   p2;
        logic                z1;
        logic                z2;
    } comb_t;

    typedef struct packed {
        logic [CWP_W-1:0]    cwp;
        logic [NWINDOWS-1:0] wim;
        logic                ack;
        logic                err;
        logic                ovf;
        logic                unf;
        logic                busy;
    } reg_t;

    comb_t comb_q[$];
    reg_t  reg_q[$];

    int unsigned total = 0;
    int unsigned bad   = 0;

    // Reference state: trap kind 0 = none, 1 = overflow, 2 = underflow
    int unsigned         m_cwp;
    logic [NWINDOWS-1:0] m_wim;
    int unsigned         m_trap;
    bit                  m_known = 1'b0;

    function automatic int unsigned phys(input int unsigned w, input int unsigned r);
        if (r < 8)  return r;
        if (r < 16) return 8 + 16 * w + (r - 8);
        if (r < 24) return 8 + 16 * w + 8 + (r - 16);
        return 8 + 16 * ((w + 1) % NWINDOWS) + (r - 24);
    endfunction

    function automatic stim_t nop();
        stim_t s;
        s = '0;
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s         = '0;
        s.clr     = ($urandom_range(63) == 0);
        s.save    = ($urandom_range(2) == 0);
        s.restore = ($urandom_range(2) == 0);
        s.ack     = ($urandom_range(3) == 0);
        s.cwp_we  = ($urandom_range(9) == 0);
        s.cwp_din = CWP_W'($urandom);
        s.wim_we  = ($urandom_range(7) == 0);
        s.wim_din = NWINDOWS'($urandom & $urandom & $urandom);
        s.wr_en   = ($urandom_range(1) == 0);
        s.wr_rd   = 5'($urandom);
        s.rs1     = 5'($urandom);
        s.rs2     = 5'($urandom);
        return s;
    endfunction

    task automatic chk(input string nm, input logic [NPHYS-1:0] act, input logic [NPHYS-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input stim_t s);
        comb_t       c;
        reg_t        r;
        int unsigned n;
        logic [NWINDOWS-1:0] next_wim;
        @(posedge Clk);
        #1;
        Clr             = s.clr;
        bus.save_req    = s.save;
        bus.restore_req = s.restore;
        bus.trap_ack    = s.ack;
        bus.cwp_we      = s.cwp_we;
        bus.cwp_din     = s.cwp_din;
        bus.wim_we      = s.wim_we;
        bus.wim_din     = s.wim_din;
        bus.wr_en       = s.wr_en;
        bus.wr_rd       = s.wr_rd;
        bus.rs1         = s.rs1;
        bus.rs2         = s.rs2;

        c = '0;
        c.valid = m_known;
        if (s.wr_en && s.wr_rd != 0)
            c.le[phys(m_cwp, s.wr_rd)] = 1'b1;
        c.p1 = PIDX_W'(phys(m_cwp, s.rs1));
        c.p2 = PIDX_W'(phys(m_cwp, s.rs2));
        c.z1 = (s.rs1 == 0);
        c.z2 = (s.rs2 == 0);
        comb_q.push_back(c);

        r = '0;
        if (s.clr) begin
            m_cwp   = 0;
            m_wim   = '0;
            m_trap  = 0;
            m_known = 1'b1;
        end else begin
            next_wim = s.wim_we ? s.wim_din : m_wim;
            if (m_trap == 0) begin
                if (s.cwp_we) begin
                    m_cwp = s.cwp_din % NWINDOWS;
                end else if (s.save && s.restore) begin
                    r.err = 1'b1;
                end else if (s.save) begin
                    n = (m_cwp + NWINDOWS - 1) % NWINDOWS;
                    if (m_wim[n]) m_trap = 1;
                    else begin m_cwp = n; r.ack = 1'b1; end
                end else if (s.restore) begin
                    n = (m_cwp + 1) % NWINDOWS;
                    if (m_wim[n]) m_trap = 2;
                    else begin m_cwp = n; r.ack = 1'b1; end
                end
            end else begin
                if (s.cwp_we) m_cwp = s.cwp_din % NWINDOWS;
                if (s.ack) m_trap = 0;
            end
            m_wim = next_wim;
        end
        r.cwp  = CWP_W'(m_cwp);
        r.wim  = m_wim;
        r.ovf  = (m_trap == 1);
        r.unf  = (m_trap == 2);
        r.busy = (m_trap != 0);
        reg_q.push_back(r);
    endtask

    // Monitor: combinational expectations are due in the same cycle,
    // registered expectations one clock edge later.
    initial begin
        reg_t  hold;
        comb_t c;
        bit    hold_v = 1'b0;
        forever begin
            @(negedge Clk);
            if (hold_v) begin
                chk("cwp",      NPHYS'(bus.cwp),      NPHYS'(hold.cwp));
                chk("wim",      NPHYS'(bus.wim),      NPHYS'(hold.wim));
                chk("op_ack",   NPHYS'(bus.op_ack),   NPHYS'(hold.ack));
                chk("op_err",   NPHYS'(bus.op_err),   NPHYS'(hold.err));
                chk("trap_ovf", NPHYS'(bus.trap_ovf), NPHYS'(hold.ovf));
                chk("trap_unf", NPHYS'(bus.trap_unf), NPHYS'(hold.unf));
                chk("busy",     NPHYS'(bus.busy),     NPHYS'(hold.busy));
            end
            hold_v = 1'b0;
            if (reg_q.size() > 0) begin
                hold   = reg_q.pop_front();
                hold_v = 1'b1;
            end
            if (comb_q.size() > 0) begin
                c = comb_q.pop_front();
                if (c.valid) begin
                    chk("le",       bus.le,                c.le);
                    chk("rs1_pidx", NPHYS'(bus.rs1_pidx),  NPHYS'(c.p1));
                    chk("rs2_pidx", NPHYS'(bus.rs2_pidx),  NPHYS'(c.p2));
                    chk("rs1_zero", NPHYS'(bus.rs1_zero),  NPHYS'(c.z1));
                    chk("rs2_zero", NPHYS'(bus.rs2_zero),  NPHYS'(c.z2));
                end
            end
        end
    end

    initial begin
        stim_t s;
        Clr = 1'b1;
        bus.save_req = 1'b0; bus.restore_req = 1'b0; bus.trap_ack = 1'b0;
        bus.cwp_we = 1'b0;   bus.cwp_din = '0;       bus.wim_we = 1'b0;
        bus.wim_din = '0;    bus.wr_en = 1'b0;       bus.wr_rd = '0;
        bus.rs1 = '0;        bus.rs2 = '0;

        // Reset, then write decode of r8 and the dropped r0 write
        s = nop(); s.clr = 1'b1; step(s); step(s);
        s = nop(); s.wr_en = 1'b1; s.wr_rd = 5'd8; step(s);
        s.wr_rd = 5'd0; step(s);

        // SAVE 0 -> 7, then ins/locals of window 7
        s = nop(); s.save = 1'b1; step(s);
        s = nop(); s.rs1 = 5'd24; s.rs2 = 5'd31; step(s);
        s.rs1 = 5'd16; s.rs2 = 5'd23; step(s);

        // Overflow trap, saves ignored while trapped, release by trap_ack
        s = nop(); s.cwp_we = 1'b1; s.cwp_din = '0; s.wim_we = 1'b1; s.wim_din = 8'h80; step(s);
        s = nop(); s.save = 1'b1; step(s); step(s); step(s);
        s = nop(); s.ack = 1'b1; step(s);
        s = nop(); step(s);

        // Underflow trap from window 7
        s = nop(); s.cwp_we = 1'b1; s.cwp_din = CWP_W'(7); s.wim_we = 1'b1; s.wim_din = 8'h01; step(s);
        s = nop(); s.restore = 1'b1; step(s);
        s = nop(); step(s);
        s.ack = 1'b1; step(s);

        // Simultaneous requests, then cwp_we beating a save
        s = nop(); s.wim_we = 1'b1; s.wim_din = '0; step(s);
        s = nop(); s.save = 1'b1; s.restore = 1'b1; step(s);
        s = nop(); s.save = 1'b1; s.cwp_we = 1'b1; s.cwp_din = CWP_W'(5); step(s);
        s = nop(); s.save = 1'b1; step(s); step(s); step(s);

        // Clr while trapped
        s = nop(); s.cwp_we = 1'b1; s.cwp_din = '0; s.wim_we = 1'b1; s.wim_din = 8'h80; step(s);
        s = nop(); s.save = 1'b1; step(s);
        s = nop(); step(s);
        s.clr = 1'b1; step(s);
        s = nop(); step(s);

        for (int unsigned i = 0; i < 800; i++)
            step(rand_stim());

        repeat (2) @(negedge Clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
